// File: rtl/aes_pkg.sv
// Shared AES definitions: MixColumns FSM encoding, GF(2^8) multiply helpers
// built from xtime chains, and column/byte slice macros for the 128-bit state.
`ifndef AES_PKG_SV
`define AES_PKG_SV

// Column i of a column-major state (col0 in the top 32 bits).
`define AES_COL(s, i) s[127-32*(i) -: 32]
// Row r of a 32-bit column (row0 in the top byte).
`define AES_BYTE(c, r) c[31-8*(r) -: 8]

package aes_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mcs_state_e;

  localparam logic [7:0] AES_POLY = 8'h1b;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul2(input logic [7:0] b);
    return xtime(b);
  endfunction

  function automatic logic [7:0] gf_mul3(input logic [7:0] b);
    return xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] gf_mul9(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic logic [7:0] gf_mulb(input logic [7:0] b);
    logic [7:0] x2;
    x2 = xtime(b);
    return xtime(xtime(x2)) ^ x2 ^ b;
  endfunction

  function automatic logic [7:0] gf_muld(input logic [7:0] b);
    logic [7:0] x4;
    x4 = xtime(xtime(b));
    return xtime(x4) ^ x4 ^ b;
  endfunction

  function automatic logic [7:0] gf_mule(input logic [7:0] b);
    logic [7:0] x2;
    logic [7:0] x4;
    x2 = xtime(b);
    x4 = xtime(x2);
    return xtime(x4) ^ x4 ^ x2;
  endfunction

endpackage

`endif

// File: rtl/mix_column_unit.sv
// Combinational single-column MixColumns / InvMixColumns transform.
module mix_column_unit
  import aes_pkg::*;
(
  input  logic [31:0] col,
  input  logic        inv,
  output logic [31:0] result
);

  logic [7:0] a0, a1, a2, a3;

  assign a0 = `AES_BYTE(col, 0);
  assign a1 = `AES_BYTE(col, 1);
  assign a2 = `AES_BYTE(col, 2);
  assign a3 = `AES_BYTE(col, 3);

  always_comb begin
    result = '0;
    if (inv) begin
      `AES_BYTE(result, 0) = gf_mule(a0) ^ gf_mulb(a1) ^ gf_muld(a2) ^ gf_mul9(a3);
      `AES_BYTE(result, 1) = gf_mul9(a0) ^ gf_mule(a1) ^ gf_mulb(a2) ^ gf_muld(a3);
      `AES_BYTE(result, 2) = gf_muld(a0) ^ gf_mul9(a1) ^ gf_mule(a2) ^ gf_mulb(a3);
      `AES_BYTE(result, 3) = gf_mulb(a0) ^ gf_muld(a1) ^ gf_mul9(a2) ^ gf_mule(a3);
    end else begin
      `AES_BYTE(result, 0) = gf_mul2(a0) ^ gf_mul3(a1) ^ a2 ^ a3;
      `AES_BYTE(result, 1) = a0 ^ gf_mul2(a1) ^ gf_mul3(a2) ^ a3;
      `AES_BYTE(result, 2) = a0 ^ a1 ^ gf_mul2(a2) ^ gf_mul3(a3);
      `AES_BYTE(result, 3) = gf_mul3(a0) ^ a1 ^ a2 ^ gf_mul2(a3);
    end
  end

endmodule

// File: rtl/mix_columns_seq.sv
// Iterative MixColumns engine: transforms COLS_PER_CYCLE columns per clock in
// place, then holds the finished block until downstream accepts it.
module mix_columns_seq
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy,
  output logic [1:0]   dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; valid may not drop and data may not change until that edge.

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_param
    $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam int N  = 4 / COLS_PER_CYCLE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  function automatic logic [31:0] get_col(input logic [127:0] s, input logic [1:0] i);
    logic [31:0] c;
    c = '0;
    unique case (i)
      2'd0: c = `AES_COL(s, 0);
      2'd1: c = `AES_COL(s, 1);
      2'd2: c = `AES_COL(s, 2);
      2'd3: c = `AES_COL(s, 3);
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic logic [127:0] set_col(input logic [127:0] s, input logic [1:0] i,
                                           input logic [31:0] v);
    logic [127:0] r;
    r = s;
    unique case (i)
      2'd0: `AES_COL(r, 0) = v;
      2'd1: `AES_COL(r, 1) = v;
      2'd2: `AES_COL(r, 2) = v;
      2'd3: `AES_COL(r, 3) = v;
      default: r = s;
    endcase
    return r;
  endfunction

  mcs_state_e     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [127:0]   work_q, work_d;
  logic           inv_q, inv_d;
  logic [1:0]     base;
  logic [127:0]   run_data;
  logic [31:0]    col_in  [COLS_PER_CYCLE];
  logic [31:0]    col_out [COLS_PER_CYCLE];

  // First column of the group handled this cycle.
  assign base = 2'(int'(cnt_q) * COLS_PER_CYCLE);

  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_unit
    logic [1:0] idx;
    assign idx       = base + 2'(g);
    assign col_in[g] = get_col(work_q, idx);
    mix_column_unit u_mcu (
      .col    (col_in[g]),
      .inv    (inv_q),
      .result (col_out[g])
    );
  end

  always_comb begin
    run_data = work_q;
    for (int g = 0; g < COLS_PER_CYCLE; g++) begin
      run_data = set_col(run_data, base + 2'(g), col_out[g]);
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    inv_d     = inv_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          work_d  = in_data;
          inv_d   = in_inv;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        work_d = run_data;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      inv_q   <= inv_d;
    end
  end

  assign out_data  = work_q;
  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

endmodule
